alu_nibble_seq: RTL and testbench
=================================

Name: alu_nibble_seq

Overview:
- Sequences a single external 4-bit MC10181-style ALU slice nibble-serially to perform a full-width (default 36-bit) ALU operation.
- Latches operands and function select on a start handshake, then presents one nibble per clock to the slice, least significant nibble first.
- Chains the slice carry between nibbles and assembles the result word.
- Used where a full parallel carry-lookahead ALU is not justified (e.g. maintenance/diagnostic datapaths), sharing one slice across a wide word.

Parameters:
- NIBBLES, 9, number of 4-bit nibbles per operation; data width W = 4*NIBBLES.
- IDXW, 4, width of nibble index counter; must satisfy 2**IDXW >= NIBBLES.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request an operation; accepted only when ready=1.
- ready  out  1  block idle, can accept start.
- abort  in  1  synchronous abandon of the operation in progress.
- op_a  in  W  operand A, sampled at start acceptance.
- op_b  in  W  operand B, sampled at start acceptance.
- op_s  in  4  function select S, sampled at start acceptance.
- op_m  in  1  mode M (1 = logic, no carry), sampled at start acceptance.
- op_cin  in  1  carry into nibble 0, sampled at start acceptance.
- alu_a  out  4  current A nibble to slice.
- alu_b  out  4  current B nibble to slice.
- alu_s  out  4  latched S to slice.
- alu_m  out  1  latched M to slice.
- alu_cin  out  1  carry into slice for current nibble.
- alu_f  in  4  slice function output, combinational from alu_* outputs.
- alu_cout  in  1  slice carry out, combinational.
- result  out  W  assembled result, held until the next accepted start.
- cout  out  1  alu_cout captured from the final nibble.
- zero  out  1  result == 0.
- done  out  1  one-cycle pulse when result, cout and zero are valid.

Behaviour:
- States: IDLE, RUN, DONE. Reset forces:
  - state=IDLE, idx=0.
  - a_reg, b_reg, result=0; s_reg=0; m_reg=0; cin_reg=0; carry=0.
  - cout=0, done=0, ready=1, zero=1.
- IDLE: ready=1.
  - start=1 at a clock edge: latch op_a/op_b/op_s/op_m/op_cin, clear result to 0, set idx=0, go to RUN.
  - start while not in IDLE is ignored (no queuing).
- RUN: ready=0. Outputs are combinational from registers:
  - alu_a = a_reg[4*idx+:4], alu_b = b_reg[4*idx+:4].
  - alu_s = s_reg, alu_m = m_reg.
  - alu_cin = cin_reg when idx==0, else carry.
- Each RUN edge:
  - result[4*idx+:4] <= alu_f; carry <= alu_cout.
  - If idx==NIBBLES-1: cout <= alu_cout, go to DONE. Otherwise idx <= idx+1.
- The carry is passed through unchanged in polarity; M=1 operations still chain carry, and the slice ignores it.
- DONE: done=1 for exactly one cycle, ready=0; next edge goes to IDLE, idx=0.
- Latency: start accepted at edge 0; nibble k captured at edge k+1; done high in the cycle after edge NIBBLES. With defaults, done is high in the cycle following edge 9; ready returns in the cycle after edge 10.
- result, cout and zero hold stable from done until the next accepted start. result is cleared at start acceptance, so zero=1 during RUN.
- abort=1 in RUN or DONE: next edge goes to IDLE, done not asserted (or deasserted), result left as partially written.
- abort has priority over nibble capture and over start. abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: abort wins, start is not accepted.
- reset_n low mid-operation: immediate return to reset values; no done is produced.
- alu_* outputs in IDLE/DONE:
  - alu_a, alu_b show nibble 0 of the latched operands.
  - alu_cin = cin_reg.
  - Downstream ignores them in these states.

Test Plan:
- Bench uses a stub slice, F = A+B+CIN mod 16, COUT = carry out.
- Reset, then release: ready=1, done=0, result=0, zero=1, cout=0; all alu_* outputs 0.
- Add with full ripple: op_a=36'hFFFFFFFFF, op_b=36'h000000001, op_cin=0 -> exactly 9 RUN cycles; alu_cin=1 on nibbles 1..8; done one cycle; result=0, zero=1, cout=1.
- Simple add: op_a=36'h123456789, op_b=36'h111111111, op_cin=1 -> result=36'h23456789B, cout=0, zero=0. done is high in the 10th cycle after the start-accept edge; ready=1 the cycle after.
- start held high continuously through RUN/DONE with changing operands -> only the first operands are used; a second operation begins only after ready=1, and its result reflects operands present at that acceptance edge.
- abort asserted during RUN at idx=4 -> no done pulse; IDLE next cycle, ready=1; result low nibbles 0..3 written, upper nibbles 0.
- reset_n pulsed low at idx=6 -> all outputs immediately at reset values, no done. A following operation (op_a=1, op_b=1, cin=0) yields result=2, cout=0.

Source files
------------

// File: rtl/alu_nibble_seq_if.sv
// Bus between the nibble sequencer and one external 4-bit ALU slice.
// The sequencer drives operands/function; the slice returns F and carry-out.
interface alu_nibble_seq_if;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_s;
    logic       alu_m;
    logic       alu_cin;
    logic [3:0] alu_f;
    logic       alu_cout;

    modport master (
        output alu_a, alu_b, alu_s, alu_m, alu_cin,
        input  alu_f, alu_cout
    );

    modport slave (
        input  alu_a, alu_b, alu_s, alu_m, alu_cin,
        output alu_f, alu_cout
    );
endinterface

// File: rtl/alu_nibble_seq.sv
// Runs a full-width ALU operation through a single shared 4-bit slice,
// one nibble per clock, least significant nibble first, chaining the carry.
module alu_nibble_seq #(
    parameter int NIBBLES = 9,
    parameter int IDXW    = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    output logic                   ready,
    input  logic                   abort,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic [3:0]             op_s,
    input  logic                   op_m,
    input  logic                   op_cin,
    alu_nibble_seq_if.master       alu,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   zero,
    output logic                   done
);
    localparam int W = 4 * NIBBLES;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [IDXW-1:0]   idx_r;
    logic [W-1:0]      a_r;
    logic [W-1:0]      b_r;
    logic [W-1:0]      result_r;
    logic [3:0]        s_r;
    logic              m_r;
    logic              cin_r;
    logic              carry_r;
    logic              cout_r;
    logic              done_r;
    logic              ready_r;
    logic [IDXW+1:0]   off_s;
    logic              last_s;

    // idx is forced back to 0 whenever RUN is left, so outside RUN the slice
    // sees nibble 0 of the latched operands and cin_r as carry-in.
    assign off_s        = {idx_r, 2'b00};
    assign last_s       = (idx_r == IDXW'(NIBBLES - 1));
    assign alu.alu_a    = a_r[off_s +: 4];
    assign alu.alu_b    = b_r[off_s +: 4];
    assign alu.alu_s    = s_r;
    assign alu.alu_m    = m_r;
    assign alu.alu_cin  = (idx_r == {IDXW{1'b0}}) ? cin_r : carry_r;

    assign result = result_r;
    assign cout   = cout_r;
    assign done   = done_r;
    assign ready  = ready_r;
    assign zero   = (result_r == {W{1'b0}});

    // Sequencer FSM: operand latch, per-nibble capture, carry chaining, status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            idx_r    <= {IDXW{1'b0}};
            a_r      <= {W{1'b0}};
            b_r      <= {W{1'b0}};
            result_r <= {W{1'b0}};
            s_r      <= 4'd0;
            m_r      <= 1'b0;
            cin_r    <= 1'b0;
            carry_r  <= 1'b0;
            cout_r   <= 1'b0;
            done_r   <= 1'b0;
            ready_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    // abort outranks start even while idle
                    if (start && !abort) begin
                        a_r      <= op_a;
                        b_r      <= op_b;
                        s_r      <= op_s;
                        m_r      <= op_m;
                        cin_r    <= op_cin;
                        result_r <= {W{1'b0}};
                        idx_r    <= {IDXW{1'b0}};
                        ready_r  <= 1'b0;
                        state_r  <= ST_RUN;
                    end else begin
                        ready_r  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        idx_r   <= {IDXW{1'b0}};
                        done_r  <= 1'b0;
                        ready_r <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        result_r[off_s +: 4] <= alu.alu_f;
                        carry_r              <= alu.alu_cout;
                        if (last_s) begin
                            cout_r  <= alu.alu_cout;
                            idx_r   <= {IDXW{1'b0}};
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            idx_r   <= idx_r + IDXW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    idx_r   <= {IDXW{1'b0}};
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    idx_r   <= {IDXW{1'b0}};
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq using an adder stub as the slice
// and a whole-word arithmetic reference model.
module tb_alu_nibble_seq;
    localparam int NIB = 9;
    localparam int W   = 4 * NIB;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic         ready;
    logic         abort;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [3:0]   op_s;
    logic         op_m;
    logic         op_cin;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
    logic         done;

    int checks;
    int failures;

    alu_nibble_seq_if alu_if ();

    // stub slice: 4-bit adder
    assign {alu_if.alu_cout, alu_if.alu_f} = 5'(alu_if.alu_a) + 5'(alu_if.alu_b) + 5'(alu_if.alu_cin);

    alu_nibble_seq #(.NIBBLES(NIB), .IDXW(4)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .ready  (ready),
        .abort  (abort),
        .op_a   (op_a),
        .op_b   (op_b),
        .op_s   (op_s),
        .op_m   (op_m),
        .op_cin (op_cin),
        .alu    (alu_if),
        .result (result),
        .cout   (cout),
        .zero   (zero),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   s;
        logic         m;
        logic         cin;
        logic [W-1:0] exp_res;
        logic         exp_cout;
    } vec_t;

    vec_t tbl [6];

    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // carry into nibble k = carry out of the low 4k bits of the whole-word sum
    function automatic logic ref_cin(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int k);
        logic [W:0] mask;
        logic [W:0] s;
        mask = ({{W{1'b0}}, 1'b1} << (4 * k)) - {{W{1'b0}}, 1'b1};
        s    = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {{W{1'b0}}, c};
        return s[4 * k];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                          input logic m, input logic cin);
        op_a   = a;
        op_b   = b;
        op_s   = s;
        op_m   = m;
        op_cin = cin;
        start  = 1'b1;
    endtask

    task automatic scramble_ops();
        logic [63:0] r;
        r      = {$urandom(), $urandom()};
        op_a   = r[W-1:0];
        r      = {$urandom(), $urandom()};
        op_b   = r[W-1:0];
        op_s   = 4'($urandom_range(15, 0));
        op_m   = 1'($urandom_range(1, 0));
        op_cin = 1'($urandom_range(1, 0));
    endtask

    // Called at a negedge with the operation already driven; returns at the
    // negedge where ready is back, having checked every RUN cycle and the done cycle.
    task automatic run_check(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                             input logic m, input logic cin, input logic [W-1:0] exp_res,
                             input logic exp_cout, input bit hold);
        chk("ready_before_start", 64'(ready), 64'd1);
        @(posedge clk);
        for (int k = 0; k < NIB; k++) begin
            @(negedge clk);
            if (hold) scramble_ops();
            else start = 1'b0;
            chk("run_ready",   64'(ready), 64'd0);
            chk("run_done",    64'(done),  64'd0);
            chk("run_alu_a",   64'(alu_if.alu_a), 64'(a[4*k +: 4]));
            chk("run_alu_b",   64'(alu_if.alu_b), 64'(b[4*k +: 4]));
            chk("run_alu_s",   64'(alu_if.alu_s), 64'(s));
            chk("run_alu_m",   64'(alu_if.alu_m), 64'(m));
            chk("run_alu_cin", 64'(alu_if.alu_cin), 64'(ref_cin(a, b, cin, k)));
        end
        @(negedge clk);
        if (hold) scramble_ops();
        chk("done_pulse",  64'(done),   64'd1);
        chk("done_ready",  64'(ready),  64'd0);
        chk("result",      64'(result), 64'(exp_res));
        chk("cout",        64'(cout),   64'(exp_cout));
        chk("zero",        64'(zero),   64'(exp_res == {W{1'b0}}));
        @(negedge clk);
        chk("done_single", 64'(done),   64'd0);
        chk("ready_after", 64'(ready),  64'd1);
        chk("result_hold", 64'(result), 64'(exp_res));
        chk("cout_hold",   64'(cout),   64'(exp_cout));
    endtask

    initial begin
        logic [W:0]   sum;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [63:0]  r;
        logic         rc;

        checks   = 0;
        failures = 0;

        tbl[0] = '{36'hFFFFFFFFF, 36'h000000001, 4'h9, 1'b0, 1'b0, 36'h000000000, 1'b1};
        tbl[1] = '{36'h123456789, 36'h111111111, 4'h9, 1'b0, 1'b1, 36'h23456789B, 1'b0};
        tbl[2] = '{36'h000000000, 36'h000000000, 4'h6, 1'b1, 1'b0, 36'h000000000, 1'b0};
        tbl[3] = '{36'h800000000, 36'h800000000, 4'h3, 1'b0, 1'b0, 36'h000000000, 1'b1};
        tbl[4] = '{36'hFFFFFFFFF, 36'hFFFFFFFFF, 4'hA, 1'b1, 1'b1, 36'hFFFFFFFFF, 1'b1};
        tbl[5] = '{36'h0F0F0F0F0, 36'h10F0F0F10, 4'h5, 1'b0, 1'b0, 36'h200000000, 1'b0};

        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        op_a    = {W{1'b0}};
        op_b    = {W{1'b0}};
        op_s    = 4'd0;
        op_m    = 1'b0;
        op_cin  = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready",  64'(ready),  64'd1);
        chk("rst_done",   64'(done),   64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_zero",   64'(zero),   64'd1);
        chk("rst_cout",   64'(cout),   64'd0);
        chk("rst_alu",    64'({alu_if.alu_a, alu_if.alu_b, alu_if.alu_s, alu_if.alu_m, alu_if.alu_cin}), 64'd0);

        // directed table
        for (int i = 0; i < 6; i++) begin
            launch(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].m, tbl[i].cin);
            run_check(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].m, tbl[i].cin,
                      tbl[i].exp_res, tbl[i].exp_cout, 1'b0);
        end

        // randomized operations against the whole-word model
        for (int i = 0; i < 20; i++) begin
            r  = {$urandom(), $urandom()};
            ra = r[W-1:0];
            r  = {$urandom(), $urandom()};
            rb = (i % 4 == 0) ? ~ra : r[W-1:0];
            rc = 1'($urandom_range(1, 0));
            sum = ref_sum(ra, rb, rc);
            launch(ra, rb, 4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), rc);
            run_check(ra, rb, op_s, op_m, rc, sum[W-1:0], sum[W], 1'b0);
        end

        // start held high with operands changing under it
        launch(36'h0ABCDEF01, 36'h123456789, 4'h9, 1'b0, 1'b0);
        sum = ref_sum(36'h0ABCDEF01, 36'h123456789, 1'b0);
        run_check(36'h0ABCDEF01, 36'h123456789, 4'h9, 1'b0, 1'b0, sum[W-1:0], sum[W], 1'b1);
        launch(36'h555555555, 36'hAAAAAAAAB, 4'h2, 1'b1, 1'b1);
        sum = ref_sum(36'h555555555, 36'hAAAAAAAAB, 1'b1);
        run_check(36'h555555555, 36'hAAAAAAAAB, 4'h2, 1'b1, 1'b1, sum[W-1:0], sum[W], 1'b0);

        // abort at idx 4: nibbles 0..3 kept, no done
        launch(36'h123456789, 36'h111111111, 4'h9, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ready",  64'(ready),  64'd1);
        chk("abort_done",   64'(done),   64'd0);
        chk("abort_result", 64'(result), 64'h00000789B);
        @(negedge clk);
        chk("abort_no_done", 64'(done), 64'd0);

        // start and abort together while idle: start is refused
        launch(36'h000000001, 36'h000000001, 4'h9, 1'b0, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("idle_abort_ready",  64'(ready),  64'd1);
        chk("idle_abort_result", 64'(result), 64'h00000789B);
        @(negedge clk);
        chk("idle_abort_still_ready", 64'(ready), 64'd1);

        // leave cout=1 behind, then reset in the middle of the next operation
        launch(36'hFFFFFFFFF, 36'h000000001, 4'h9, 1'b0, 1'b0);
        run_check(36'hFFFFFFFFF, 36'h000000001, 4'h9, 1'b0, 1'b0, 36'h000000000, 1'b1, 1'b0);
        launch(36'h123456789, 36'h876543210, 4'hC, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ready",  64'(ready),  64'd1);
        chk("mid_rst_done",   64'(done),   64'd0);
        chk("mid_rst_result", 64'(result), 64'd0);
        chk("mid_rst_zero",   64'(zero),   64'd1);
        chk("mid_rst_cout",   64'(cout),   64'd0);
        chk("mid_rst_alu",    64'({alu_if.alu_a, alu_if.alu_b, alu_if.alu_s, alu_if.alu_m, alu_if.alu_cin}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_done",  64'(done),  64'd0);
        chk("post_rst_ready", 64'(ready), 64'd1);
        launch(36'h000000001, 36'h000000001, 4'h9, 1'b0, 1'b0);
        run_check(36'h000000001, 36'h000000001, 4'h9, 1'b0, 1'b0, 36'h000000002, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
